// File: rtl/f1_pkg.sv
// Shared definitions for the f1 start-light sequencer: state encoding and LFSR constants.
package f1_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t FILL = 2'd1;
    localparam state_t HOLD = 2'd2;

    localparam int unsigned LFSR_W = 7;

    // Feedback taps for x^7 + x^6 + 1 (bits 6 and 5 of the shift register)
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 7'h60;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 7'h01;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/f1_lfsr.sv
// Free-running 7-bit Fibonacci LFSR (x^7 + x^6 + 1) used as the random hold-delay source.
module f1_lfsr
    import f1_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);

    // An all-zero seed would lock the register up, so fall back to the default.
    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_SEED_DEF : SEED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED_SAFE;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/f1_light_seq.sv
// Start-light sequencer: fills NUM_LIGHTS lights one per tick, holds, then pulses go.
// Define F1_SEQ_RAND_DELAY_EN to take the hold delay from an LFSR instead of HOLD_TICKS.
module f1_light_seq
    import f1_pkg::*;
#(
    parameter int unsigned       NUM_LIGHTS = 8,
    parameter int unsigned       DELAY_W    = 7,
    parameter int unsigned       HOLD_TICKS = 20,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  tick,
    input  logic                  abort,
    output logic [NUM_LIGHTS-1:0] data_out,
    output logic                  busy,
    output logic                  go
);

    if (NUM_LIGHTS < 2 || NUM_LIGHTS > 16) begin : g_bad_lights
        $error("f1_light_seq: NUM_LIGHTS must be in 2..16");
    end
    if (HOLD_TICKS < 1 || HOLD_TICKS > (1 << DELAY_W) - 1) begin : g_bad_hold
        $error("f1_light_seq: HOLD_TICKS must be in 1..2^DELAY_W-1");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("f1_light_seq: LFSR_SEED must be non-zero");
    end

    state_t                state_q, state_d;
    logic [NUM_LIGHTS-1:0] data_q, data_d;
    logic [DELAY_W-1:0]    cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  go_q, go_d;
    logic [DELAY_W-1:0]    delay_load;

`ifdef F1_SEQ_RAND_DELAY_EN
    logic [LFSR_W-1:0]  lfsr_q;
    logic [DELAY_W-1:0] lfsr_fit;

    f1_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Zero-extend or truncate to the counter width; a zero delay would never expire.
    always_comb begin
        lfsr_fit   = DELAY_W'(lfsr_q);
        delay_load = (lfsr_fit == '0) ? DELAY_W'(1) : lfsr_fit;
    end
`else
    always_comb begin
        delay_load = DELAY_W'(HOLD_TICKS);
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        go_d    = 1'b0;

        case (state_q)
            IDLE: begin
                data_d = '0;
                if (trigger) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                    data_d  = '0;
                end else if (tick) begin
                    // The full pattern is shown for one tick before the hold count starts.
                    if (&data_q) begin
                        cnt_d   = delay_load;
                        state_d = HOLD;
                    end else begin
                        data_d = {data_q[NUM_LIGHTS-2:0], 1'b1};
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    data_d  = '0;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == DELAY_W'(1)) begin
                        state_d = IDLE;
                        data_d  = '0;
                        cnt_d   = '0;
                        go_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DELAY_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == FILL) || (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign go       = go_q;

endmodule

// File: doc/f1_light_seq.md
Name: f1_light_seq

Overview:
- Parametrised successor to the fixed 8-light start-light FSM.
- Sequences NUM_LIGHTS lights on, one per `tick`, then holds all lights on for a delay, then extinguishes them all and pulses `go`.
- Adds a start trigger, an abort, and a timebase strobe instead of advancing every enabled cycle.
- Sits between the board timebase/button logic and the LED/display driver.

Parameters:
- NUM_LIGHTS, 8: number of lights; legal range 2..16.
- DELAY_W, 7: width of the hold-delay counter.
- HOLD_TICKS, 20: fixed hold delay in ticks when the random delay is compiled out; legal range 1..2^DELAY_W-1.
- LFSR_SEED, 7'h01: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- trigger  in  1  start request; level sampled each clk, acted on only in IDLE.
- tick  in  1  one-clk timebase strobe; every light/delay step happens only on a cycle with tick=1.
- abort  in  1  synchronous cancel; highest priority after reset.
- data_out  out  NUM_LIGHTS  light pattern, thermometer-coded from bit 0.
- busy  out  1  high in FILL and HOLD.
- go  out  1  single-clk pulse when the lights go out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, data_out=0, busy=0, go=0, counter=0, LFSR=LFSR_SEED.
  - Reset during FILL or HOLD aborts immediately; no go is produced.
- States: IDLE, FILL, HOLD. All outputs are registered.
- IDLE:
  - data_out=0.
  - trigger=1 -> FILL on the next clk, with data_out still 0.
  - A tick in the same cycle as trigger is ignored.
- FILL, on tick:
  - If data_out is not all-ones: data_out <= {data_out[N-2:0],1'b1}.
  - If data_out is all-ones: load the delay counter and go to HOLD; data_out is unchanged.
  - Consequence: the first light comes on at the first tick after entry. The all-ones pattern persists through HOLD.
- HOLD, on tick:
  - counter != 1: counter decrements.
  - counter == 1: data_out <= 0, go <= 1 for exactly one clk, state <= IDLE.
  - Hold length is therefore exactly `delay` ticks after the full-pattern tick.
- trigger in FILL or HOLD is ignored; there is no restart.
- abort=1 in FILL or HOLD -> next clk: data_out=0, IDLE, go=0.
  - abort beats a tick in the same cycle.
  - abort in IDLE has no effect.
- A trigger held high continuously re-arms on the first clk back in IDLE. go and re-entry to FILL are then one cycle apart.
- Cycles without tick change nothing except the LFSR.

Optional Feature:
- Macro: F1_SEQ_RAND_DELAY_EN.
- Defined:
  - A 7-bit Fibonacci LFSR (x^7+x^6+1) advances every clk, including in IDLE.
  - On FILL->HOLD the counter loads the current LFSR value, zero-extended or truncated to DELAY_W.
  - A value of 0 is forced to 1.
  - Delay range is 1..127 ticks.
- Undefined: the LFSR is absent and the counter loads HOLD_TICKS.

Decomposition:
- Package f1_pkg holds:
  - the state typedef {IDLE, FILL, HOLD};
  - LFSR width, tap constants and the default seed.
- One natural sub-module: f1_lfsr (clk, rst, q), instantiated only under F1_SEQ_RAND_DELAY_EN.

Test Plan:
- Reset mid-HOLD:
  - Stimulus: rst low for 2 clk.
  - Required: data_out=0, busy=0, go=0 asynchronously; no go follows. After release, trigger restarts from 0.
- Fixed-delay sequence (macro undefined, NUM_LIGHTS=8, HOLD_TICKS=3, tick every 4th clk, trigger pulse):
  - data_out steps 0x01,0x03,...,0xFF on successive ticks.
  - 0xFF holds for 1+3 ticks, then goes to 0x00 with a one-clk go.
  - busy is high throughout and low after.
- Parametrisation (NUM_LIGHTS=5):
  - Pattern 0x01..0x1F.
  - HOLD entered on the tick after 0x1F.
  - Bits above 4 do not exist.
- Abort:
  - Stimulus: abort coincident with a tick while data_out=0x07.
  - Required: next clk data_out=0, IDLE, go never asserts. trigger during FILL/HOLD has no effect on the pattern.
- Random delay (macro defined, seed 0x01, trigger at a known clk):
  - The loaded delay equals the reference-model LFSR value at the FILL->HOLD clk.
  - go occurs exactly that many ticks later.
  - Forced-zero case is checked via seed/model.
- Back-to-back: trigger held high -> second sequence starts one clk after go; no lost or extra go pulses.
